// File: rtl/uvmt_cv32e40s_obi_rsp_scheduler.sv
// ----------------------------------------------------------------------------
// uvmt_cv32e40s_obi_rsp_scheduler
//
// Slave-side OBI response scheduler used by the verification memory agents.
// Grants address phases and returns in-order responses. Free-running stall
// requests are honoured unless that would push the oldest outstanding
// response past MAX_OBI_STALLS+1 cycles after its address phase.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous, active-high reset
//   req_i          OBI req from the core
//   gnt_stall_i    withhold gnt this cycle (random/formal source)
//   rsp_stall_i    withhold rvalid this cycle (random/formal source)
//   limit_en_i     1: bound response latency; 0: rsp_stall_i obeyed forever
//   gnt_o          OBI gnt (combinational from current inputs and state)
//   rvalid_o       OBI rvalid (combinational from current inputs and state)
//   outstanding_o  accepted address phases still awaiting a response
//   addr_ph_cnt_o  address phase count (req_i && gnt_o), wraps
//   rsp_ph_cnt_o   response phase count (rvalid_o), wraps
//   limit_hit_o    rvalid_o forced this cycle despite rsp_stall_i
//   err_o          sticky: head missed its deadline while the limit was on
// ----------------------------------------------------------------------------
module uvmt_cv32e40s_obi_rsp_scheduler #(
  parameter int unsigned MAX_OBI_STALLS  = 8,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_i,
  input  logic                                   gnt_stall_i,
  input  logic                                   rsp_stall_i,
  input  logic                                   limit_en_i,
  output logic                                   gnt_o,
  output logic                                   rvalid_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic [CNT_W-1:0]                       addr_ph_cnt_o,
  output logic [CNT_W-1:0]                       rsp_ph_cnt_o,
  output logic                                   limit_hit_o,
  output logic                                   err_o
);

  localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned AW    = $clog2(MAX_OBI_STALLS + 3);
  localparam int unsigned DEPTH = MAX_OUTSTANDING;

  localparam logic [OW-1:0] OCC_FULL = OW'(MAX_OUTSTANDING);
  localparam logic [AW-1:0] AGE_LIM  = AW'(MAX_OBI_STALLS + 1);
  localparam logic [AW-1:0] AGE_SAT  = AW'(MAX_OBI_STALLS + 2);
  localparam logic [AW-1:0] AGE_NEW  = AW'(1);

  // Age queue: slot 0 is always the head (oldest) entry.
  logic [AW-1:0]    age_q   [DEPTH];
  logic [AW-1:0]    age_d   [DEPTH];
  logic [AW-1:0]    age_inc [DEPTH];
  logic [OW-1:0]    occ_q, occ_d, occ_after_pop;
  logic [CNT_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic             err_q, err_d;

  logic             empty_c;
  logic             full_c;
  logic             head_due_c;
  logic             push_c;
  logic             pop_c;

  assign empty_c    = (occ_q == '0);
  assign full_c     = (occ_q >= OCC_FULL);
  assign head_due_c = limit_en_i && (age_q[0] >= AGE_LIM);

  // Full FIFO never grants, even when the head pops in the same cycle.
  assign gnt_o    = !rst_i && !gnt_stall_i && !full_c;
  // A due head overrides the stall; only the head needs forcing because
  // every other entry is strictly younger.
  assign rvalid_o = !rst_i && !empty_c && (!rsp_stall_i || head_due_c);

  assign push_c      = req_i && gnt_o;
  assign pop_c       = rvalid_o;
  assign limit_hit_o = rvalid_o && rsp_stall_i;

  // Age every valid entry by one, saturating so long stalls cannot wrap.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      age_inc[i] = age_q[i];
      if ((OW'(i) < occ_q) && (age_q[i] != AGE_SAT)) begin
        age_inc[i] = age_q[i] + AW'(1);
      end
    end
  end

  // Next queue state: shift out the head on pop, then append at the tail.
  always_comb begin
    age_d         = age_inc;
    occ_after_pop = occ_q - OW'(pop_c);
    if (pop_c) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        age_d[i] = age_inc[i+1];
      end
      age_d[DEPTH-1] = '0;
    end
    if (push_c) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (OW'(i) == occ_after_pop) begin
          age_d[i] = AGE_NEW;
        end
      end
    end
    occ_d = occ_after_pop + OW'(push_c);
  end

  // Phase counters and deadline-miss flag.
  always_comb begin
    addr_cnt_d = addr_cnt_q + CNT_W'(push_c);
    rsp_cnt_d  = rsp_cnt_q + CNT_W'(pop_c);
    // A head past its limit is only an error if it is not being answered now;
    // this keeps a late 0->1 limit_en_i edge from flagging an error.
    err_d      = err_q || (!empty_c && limit_en_i && (age_q[0] > AGE_LIM) && !rvalid_o);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        age_q[i] <= '0;
      end
      occ_q      <= '0;
      addr_cnt_q <= '0;
      rsp_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      age_q      <= age_d;
      occ_q      <= occ_d;
      addr_cnt_q <= addr_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      err_q      <= err_d;
    end
  end

  assign outstanding_o = occ_q;
  assign addr_ph_cnt_o = addr_cnt_q;
  assign rsp_ph_cnt_o  = rsp_cnt_q;
  assign err_o         = err_q;

endmodule
